// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder behind valid/ready handshakes,
// reusing one full_adder slice LSB-first with the carry held in a flop.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic r,
    output logic cout
);
    assign r    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_r, fa_cout;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .r    (fa_r),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            // shift-in form keeps WIDTH=1 legal (no empty part-select)
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_r) << (WIDTH - 1));
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic c, input logic [8:0] exp);
        int  n;
        logic busy_ready;
        @(negedge clk);
        check({tag, "_idle"}, in_ready, 1);
        a = av; b = bv; cin = c; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; a = ~av; b = ~bv; cin = ~c;
        n = 0;
        busy_ready = 1'b0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            busy_ready |= in_ready;
        end while (!out_valid && n < 20);
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_ready"}, busy_ready, 0);
        check({tag, "_result"}, {cout, sum}, exp);
        @(posedge clk);
        #1 check({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    logic [8:0] q[$];

    initial begin
        int  n;
        logic flag;
        logic got;
        logic [7:0] ra, rb;
        logic rc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;

        run_op("zero", 8'h00, 8'h00, 1'b0, 9'h000);
        run_op("ripple_ff01", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("a5_5a_c1", 8'hA5, 8'h5A, 1'b1, 9'h100);
        run_op("12_34", 8'h12, 8'h34, 1'b0, 9'h046);

        // backpressure
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        check("bp_reached_done", out_valid, 1);
        in_valid = 1'b1; a = 8'h11; b = 8'h11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {in_ready, out_valid, cout, sum}, {1'b0, 1'b1, 1'b1, 8'h00});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 check("bp_release", {in_ready, out_valid}, 2'b10);

        // reset in the third RUN cycle
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_outputs", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h00});
        #1 rst_n = 1'b1;
        flag = 1'b0;
        repeat (12) begin @(negedge clk); flag |= out_valid; end
        check("mid_reset_no_result", flag, 0);
        run_op("after_reset", 8'h01, 8'h02, 1'b1, 9'h004);

        // random back-to-back with gaps on both sides
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            a = ra; b = rb; cin = rc; in_valid = 1'b1;
            q.push_back({1'b0, ra} + {1'b0, rb} + {8'h00, rc});
            @(posedge clk);
            #1 in_valid = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk);
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    check("rand_result", {cout, sum}, q.pop_front());
                    got = 1'b1;
                end
                @(posedge clk);
            end
            if (!got) check("rand_timeout", got, 1);
            #1 check("rand_no_dup", out_valid, 0);
        end
        out_ready = 1'b1;
        check("rand_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
